// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller: spawns three enemies in fixed lanes, steps them down
// the playfield, and turns projectile hits / bottom arrivals into pulses and score.
module enemy_wave_ctrl #(
  parameter int unsigned STEP_DIV    = 500000,
  parameter int unsigned SPAWN_STEPS = 40,
  parameter int unsigned LANE1_X     = 40,
  parameter int unsigned LANE2_X     = 80,
  parameter int unsigned LANE3_X     = 120,
  parameter int unsigned ENEMY_W     = 8,
  parameter int unsigned ENEMY_H     = 8,
  parameter int unsigned BOTTOM_Y    = 112
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        freeze,
  input  logic [7:0]  projectile_x,
  input  logic [7:0]  projectile_y,
  input  logic        projectile_exists,
  output logic [7:0]  enemy_1_x,
  output logic [7:0]  enemy_2_x,
  output logic [7:0]  enemy_3_x,
  output logic [7:0]  enemy_1_y,
  output logic [7:0]  enemy_2_y,
  output logic [7:0]  enemy_3_y,
  output logic [2:0]  enemy_alive,
  output logic        collision,
  output logic        health_update,
  output logic [15:0] score
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SW = (SPAWN_STEPS > 1) ? $clog2(SPAWN_STEPS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_STEPS - 1);
  localparam logic [2:0][7:0] LANE_X = {8'(LANE3_X), 8'(LANE2_X), 8'(LANE1_X)};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [1:0]      spawn_ptr_q, spawn_ptr_d;
  logic            lockout_q, lockout_d;
  logic [2:0]      alive_q, alive_d;
  logic [2:0][7:0] y_q, y_d;
  logic            collision_q, collision_d;
  logic            health_q, health_d;
  logic [15:0]     score_q, score_d;

  logic [2:0] hit_vec, hit_sel;
  logic       step, spawned, bottom;
  logic [7:0] ny;
  logic [1:0] idx;

  // Box tests are done in 9 bits so a lane near x=255 cannot wrap its right edge.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      hit_vec[i] = projectile_exists && !lockout_q && alive_q[i]
        && ({1'b0, projectile_x} >= {1'b0, LANE_X[i]})
        && ({1'b0, projectile_x} <= {1'b0, LANE_X[i]} + 9'(ENEMY_W - 1))
        && ({1'b0, projectile_y} >= {1'b0, y_q[i]})
        && ({1'b0, projectile_y} <= {1'b0, y_q[i]} + 9'(ENEMY_H - 1));
    end
    hit_sel[0] = hit_vec[0];
    hit_sel[1] = hit_vec[1] & ~hit_vec[0];
    hit_sel[2] = hit_vec[2] & ~(|hit_vec[1:0]);
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    spawn_cnt_d = spawn_cnt_q;
    spawn_ptr_d = spawn_ptr_q;
    lockout_d   = projectile_exists ? lockout_q : 1'b0;
    alive_d     = alive_q;
    y_d         = y_q;
    collision_d = 1'b0;
    health_d    = 1'b0;
    score_d     = score_q;
    step        = 1'b0;
    spawned     = 1'b0;
    bottom      = 1'b0;
    ny          = '0;
    idx         = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          score_d = '0;
        end
      end
      RUN: begin
        if (freeze) begin
          state_d = HALT;
        end else if (!start) begin
          state_d = IDLE;
        end else begin
          step    = (presc_q == PRESC_LAST);
          presc_d = step ? '0 : presc_q + 1'b1;
          if (|hit_sel) begin
            lockout_d   = 1'b1;
            collision_d = 1'b1;
            if (score_q != '1) score_d = score_q + 16'd1;
          end
          // A hit on a stepping enemy takes precedence over its descent.
          for (int unsigned i = 0; i < 3; i++) begin
            if (hit_sel[i]) begin
              alive_d[i] = 1'b0;
              y_d[i]     = '1;
            end else if (step && alive_q[i]) begin
              ny = y_q[i] + 8'd1;
              if ({1'b0, ny} >= 9'(BOTTOM_Y)) begin
                alive_d[i] = 1'b0;
                y_d[i]     = '1;
                bottom     = 1'b1;
              end else begin
                y_d[i] = ny;
              end
            end
          end
          health_d = bottom;
          if (step) begin
            if (spawn_cnt_q == SPAWN_LAST) begin
              spawn_cnt_d = '0;
              for (int unsigned k = 0; k < 3; k++) begin
                idx = 2'((32'(spawn_ptr_q) + k) % 3);
                if (!spawned && !alive_q[idx]) begin
                  spawned      = 1'b1;
                  alive_d[idx] = 1'b1;
                  y_d[idx]     = '0;
                  spawn_ptr_d  = 2'((32'(idx) + 1) % 3);
                end
              end
            end else begin
              spawn_cnt_d = spawn_cnt_q + 1'b1;
            end
          end
        end
      end
      HALT: begin
        if (!start && !freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      presc_d     = '0;
      spawn_cnt_d = '0;
      spawn_ptr_d = '0;
      lockout_d   = 1'b0;
      alive_d     = '0;
      y_d         = '1;
      collision_d = 1'b0;
      health_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      spawn_cnt_q <= '0;
      spawn_ptr_q <= '0;
      lockout_q   <= 1'b0;
      alive_q     <= '0;
      y_q         <= '1;
      collision_q <= 1'b0;
      health_q    <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      spawn_cnt_q <= spawn_cnt_d;
      spawn_ptr_q <= spawn_ptr_d;
      lockout_q   <= lockout_d;
      alive_q     <= alive_d;
      y_q         <= y_d;
      collision_q <= collision_d;
      health_q    <= health_d;
      score_q     <= score_d;
    end
  end

  assign enemy_1_x     = LANE_X[0];
  assign enemy_2_x     = LANE_X[1];
  assign enemy_3_x     = LANE_X[2];
  assign enemy_1_y     = y_q[0];
  assign enemy_2_y     = y_q[1];
  assign enemy_3_y     = y_q[2];
  assign enemy_alive   = alive_q;
  assign collision     = collision_q;
  assign health_update = health_q;
  assign score         = score_q;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl: one instance with standard lanes, one with
// overlapping lanes and a shallow bottom row.
module tb_enemy_wave_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_start, a_freeze, a_pe;
  logic [7:0]  a_px, a_py;
  logic [7:0]  a_x1, a_x2, a_x3, a_y1, a_y2, a_y3;
  logic [2:0]  a_alive;
  logic        a_coll, a_hu;
  logic [15:0] a_score;

  logic        b_start, b_freeze, b_pe;
  logic [7:0]  b_px, b_py;
  logic [7:0]  b_x1, b_x2, b_x3, b_y1, b_y2, b_y3;
  logic [2:0]  b_alive;
  logic        b_coll, b_hu;
  logic [15:0] b_score;

  enemy_wave_ctrl #(.STEP_DIV(4), .SPAWN_STEPS(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .freeze(a_freeze),
    .projectile_x(a_px), .projectile_y(a_py), .projectile_exists(a_pe),
    .enemy_1_x(a_x1), .enemy_2_x(a_x2), .enemy_3_x(a_x3),
    .enemy_1_y(a_y1), .enemy_2_y(a_y2), .enemy_3_y(a_y3),
    .enemy_alive(a_alive), .collision(a_coll), .health_update(a_hu), .score(a_score)
  );

  enemy_wave_ctrl #(.STEP_DIV(4), .SPAWN_STEPS(2), .LANE1_X(40), .LANE2_X(44),
                    .LANE3_X(120), .BOTTOM_Y(5)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .freeze(b_freeze),
    .projectile_x(b_px), .projectile_y(b_py), .projectile_exists(b_pe),
    .enemy_1_x(b_x1), .enemy_2_x(b_x2), .enemy_3_x(b_x3),
    .enemy_1_y(b_y1), .enemy_2_y(b_y2), .enemy_3_y(b_y3),
    .enemy_alive(b_alive), .collision(b_coll), .health_update(b_hu), .score(b_score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    a_start = 0; a_freeze = 0; a_pe = 0; a_px = 0; a_py = 0;
    b_start = 0; b_freeze = 0; b_pe = 0; b_px = 0; b_py = 0;
    #12;
    check("rst_alive", 32'(a_alive), 0);
    check("rst_y1", 32'(a_y1), 32'hFF);
    check("rst_score", 32'(a_score), 0);
    check("rst_coll", 32'(a_coll), 0);
    check("rst_hu", 32'(a_hu), 0);
    check("rst_x1", 32'(a_x1), 40);
    check("rst_b_x2", 32'(b_x2), 44);
    tick(1);
    rst = 1'b1;

    // First spawn after two steps of four clocks, then round-robin spawns.
    tick(1); a_start = 1;
    tick(8); check("t1_pre_alive", 32'(a_alive), 0);
    tick(1); check("t1_alive", 32'(a_alive), 1);
    check("t1_y1", 32'(a_y1), 0);
    check("t1_y2", 32'(a_y2), 32'hFF);
    tick(8); check("t1_alive2", 32'(a_alive), 3);
    check("t1_y1b", 32'(a_y1), 2);
    check("t1_y2b", 32'(a_y2), 0);
    tick(32); check("t2_y1", 32'(a_y1), 10);
    check("t2_y3", 32'(a_y3), 6);
    check("t2_alive", 32'(a_alive), 7);

    // Held projectile over enemy 1 scores once.
    a_px = 43; a_py = 14; a_pe = 1;
    tick(1); check("t2_coll", 32'(a_coll), 1);
    check("t2_y1dead", 32'(a_y1), 32'hFF);
    check("t2_score1", 32'(a_score), 1);
    check("t2_alive1", 32'(a_alive), 6);
    tick(1); check("t2_coll_one", 32'(a_coll), 0);
    tick(3); check("t2_lock_score", 32'(a_score), 1);
    check("t2_lock_coll", 32'(a_coll), 0);
    a_pe = 0;
    tick(1); check("t2_y2", 32'(a_y2), 9);
    a_px = 83; a_py = 12; a_pe = 1;
    tick(1); check("t2_coll2", 32'(a_coll), 1);
    check("t2_score2", 32'(a_score), 2);
    check("t2_alive2", 32'(a_alive), 4);
    a_pe = 0;

    // Freeze holds the field and suppresses hits.
    tick(1); check("t5_alive", 32'(a_alive), 5);
    check("t5_y1", 32'(a_y1), 0);
    check("t5_y3", 32'(a_y3), 8);
    a_freeze = 1; a_px = 123; a_py = 10; a_pe = 1;
    tick(1); check("t5_coll", 32'(a_coll), 0);
    check("t5_score", 32'(a_score), 2);
    tick(9); check("t5_y3_hold", 32'(a_y3), 8);
    check("t5_y1_hold", 32'(a_y1), 0);
    check("t5_hu", 32'(a_hu), 0);
    a_start = 0; a_freeze = 0; a_pe = 0;
    tick(1); check("t5_idle_alive", 32'(a_alive), 0);
    check("t5_idle_y3", 32'(a_y3), 32'hFF);
    check("t5_idle_score", 32'(a_score), 2);
    a_start = 1;
    tick(1); check("t5_restart_score", 32'(a_score), 0);

    // Saturation from a preloaded score.
    tick(8); check("t6_alive", 32'(a_alive), 1);
    force u_a.score_q = 16'hFFFE;
    #1;
    release u_a.score_q;
    check("t6_preload", 32'(a_score), 32'hFFFE);
    a_px = 43; a_py = 3; a_pe = 1;
    tick(1); check("t6_score_ffff", 32'(a_score), 32'hFFFF);
    check("t6_coll", 32'(a_coll), 1);
    a_pe = 0;
    tick(7); check("t6_alive2", 32'(a_alive), 2);
    a_px = 83; a_py = 3; a_pe = 1;
    tick(1); check("t6_coll2", 32'(a_coll), 1);
    check("t6_sat", 32'(a_score), 32'hFFFF);
    a_pe = 0; a_start = 0;

    // Bottom arrivals on a shallow field.
    b_start = 1;
    tick(28); check("t3_hu_pre", 32'(b_hu), 0);
    check("t3_y1", 32'(b_y1), 4);
    tick(1); check("t3_hu", 32'(b_hu), 1);
    check("t3_y1dead", 32'(b_y1), 32'hFF);
    check("t3_alive", 32'(b_alive), 6);
    tick(1); check("t3_hu_one", 32'(b_hu), 0);
    tick(6); check("t3_hu_pre2", 32'(b_hu), 0);
    tick(1); check("t3_hu2", 32'(b_hu), 1);
    tick(1); check("t3_hu2_one", 32'(b_hu), 0);

    // Overlapping lanes: lowest index wins; hit on a step suppresses bottom pulse.
    tick(3); check("t4_y1", 32'(b_y1), 2);
    check("t4_y2", 32'(b_y2), 0);
    check("t4_y3", 32'(b_y3), 4);
    b_px = 45; b_py = 4; b_pe = 1;
    tick(1); check("t4_coll", 32'(b_coll), 1);
    check("t4_score", 32'(b_score), 1);
    check("t4_alive", 32'(b_alive), 6);
    check("t4_y2_kept", 32'(b_y2), 0);
    b_pe = 0;
    tick(2); check("t4_coll_idle", 32'(b_coll), 0);
    b_px = 123; b_py = 6; b_pe = 1;
    tick(1); check("t4_coll_step", 32'(b_coll), 1);
    check("t4_hu_step", 32'(b_hu), 0);
    check("t4_score2", 32'(b_score), 2);
    check("t4_alive2", 32'(b_alive), 2);
    check("t4_y2_step", 32'(b_y2), 1);
    b_pe = 0;
    tick(1); check("t4_hu_after", 32'(b_hu), 0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_alive", 32'(b_alive), 0);
    check("t6_arst_y2", 32'(b_y2), 32'hFF);
    check("t6_arst_score", 32'(b_score), 0);
    check("t6_arst_hu", 32'(b_hu), 0);
    check("t6_arst_coll", 32'(b_coll), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
